exc_ctrl: RTL and testbench
===========================

Name: exc_ctrl

Overview:
- Exception/interrupt sequencer for the single-cycle MIPS CPU. Sits between the instruction decoder, the external interrupt lines and the CP0 register file.
- Accepts synchronous trap requests (syscall, break, teq) and external IRQs, and masks them against CP0 Status. It prioritises them, then drives CP0's exception/eret strobes, cause code and Status push/pop writes.
- Sequences the PC redirect to the handler vector and back to EPC.

Parameters:
NIRQ, 8, number of external interrupt lines (1..8)
EXC_VECTOR, 32'h00400004, handler entry address driven on pc_redirect during entry
CAUSE_INT, 5'd0, cause code for external interrupt
CAUSE_SYS, 5'd8, cause code for syscall
CAUSE_BRK, 5'd9, cause code for break
CAUSE_TEQ, 5'd13, cause code for teq trap

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
syscall_req  in  1  decoded syscall in current instruction
break_req  in  1  decoded break in current instruction
teq_req  in  1  decoded teq whose operands compared equal
eret_req  in  1  decoded eret in current instruction
irq  in  NIRQ  external interrupt lines, level, asynchronous to nothing (synchronous to clk)
pc  in  32  PC of current instruction
status  in  32  CP0 Status (reg 12) read value
epc  in  32  CP0 exc_addr / EPC value
cp0_exception  out  1  one-cycle strobe to CP0 exception input
cp0_eret  out  1  one-cycle strobe to CP0 eret input
cp0_cause  out  5  cause code accompanying cp0_exception
cp0_pc  out  32  faulting PC latched for EPC write
status_we  out  1  Status write strobe (entry shift / eret restore)
status_wdata  out  32  Status write data
stall  out  1  hold PC and block register/memory writes of current instruction
pc_sel  out  1  1 = fetch from pc_redirect this cycle
pc_redirect  out  32  redirect target
irq_ack  out  NIRQ  one-hot, one-cycle acknowledge of taken IRQ
in_handler  out  1  high between entry and completed eret

Behaviour:
- Status fields:
  - [0] IE global enable (1=enabled).
  - [1] syscall enable, [2] break enable, [3] teq enable.
  - [15:8] IM per-IRQ enable (bit 8+i for irq[i]).
- Pending IRQs: pend[i] set on rising edge of irq[i] (one-cycle registered previous value). Cleared only by its irq_ack. Set and ack in the same cycle -> set wins.
- Eligibility in IDLE:
  - sync = (teq_req&status[3]) | (break_req&status[2]) | (syscall_req&status[1]), gated by status[0].
  - int = |(pend & status[8+:NIRQ]) & status[0].
- Priority: teq > break > syscall > IRQ (lowest index wins). A masked sync request is ignored (instruction completes normally).
- FSM states: IDLE, ENTER, VECTOR, HANDLER, RETURN.
- IDLE:
  - sync or int -> ENTER. Latch cause and pc into cp0_cause/cp0_pc. For IRQ, pulse irq_ack of the selected bit in this cycle.
  - eret_req in IDLE is illegal and ignored.
- ENTER (1 cycle):
  - cp0_exception=1, stall=1.
  - status_we=1, status_wdata = status<<5 (disables all enables). Saved copy kept in CP0 upper bits.
  - -> VECTOR.
- VECTOR (1 cycle): pc_sel=1, pc_redirect=EXC_VECTOR; in_handler set -> HANDLER.
- HANDLER:
  - Normal execution; new exceptions/IRQs are not taken (nesting disallowed regardless of status).
  - eret_req -> RETURN with stall=1 that cycle.
- RETURN (1 cycle):
  - cp0_eret=1, status_we=1, status_wdata = status>>5.
  - Next cycle pc_sel=1, pc_redirect=epc (CP0 exc_addr updated at RETURN edge); in_handler cleared; -> IDLE.
- stall is asserted combinationally in the IDLE cycle a request is accepted, so the faulting instruction does not commit.
- All strobes (cp0_exception, cp0_eret, status_we, irq_ack, pc_sel) are exactly one cycle wide.
- Simultaneous sync and IRQ: sync taken, IRQ stays pending, taken after return if still enabled.
- Reset (any state, mid-sequence included):
  - state=IDLE, pend=0.
  - All strobes 0, stall=0, pc_sel=0, pc_redirect=0, cp0_cause=0, cp0_pc=0, status_wdata=0, in_handler=0.
  - An in-flight entry is abandoned with no CP0 write.

Test Plan:
1. status=0x0000000F, syscall_req with pc=0x00400100 -> the next cycle has cp0_exception=1, cp0_cause=8, cp0_pc=0x00400100, status_wdata=0x1E0. The cycle after that has pc_sel=1, pc_redirect=0x00400004.
2. In HANDLER, eret_req with epc=0x00400100 and status=0x1E0 -> cp0_eret=1 and status_wdata=0x0F. Next cycle pc_sel=1, pc_redirect=0x00400100, in_handler=0.
3. status=0x00000305, rising edge on irq[1] and irq[0] in the same cycle -> irq_ack=0x01 and cause=0. After eret, irq[1] is taken with irq_ack=0x02.
4. teq_req and syscall_req together with status=0x0F -> cause=13, one entry only. With status[3]=0, teq_req alone -> no cp0_exception and stall=0.
5. status[0]=0, syscall_req and IRQ edge -> no entry, and pend stays set. Later status=0x101 -> IRQ taken.
6. Assert rst during ENTER -> all outputs 0 and state IDLE. A subsequent syscall_req is processed normally from IDLE.

Source files
------------

// File: rtl/exc_ctrl_if.sv
// Bundle of decoder/CP0/PC-path signals between the CPU datapath and exc_ctrl.
// master = CPU side driving requests and CP0 reads, slave = the sequencer.
interface exc_ctrl_if #(
  parameter int NIRQ = 8
) ();
  logic            syscall_req;
  logic            break_req;
  logic            teq_req;
  logic            eret_req;
  logic [NIRQ-1:0] irq;
  logic [31:0]     pc;
  logic [31:0]     status;
  logic [31:0]     epc;

  logic            cp0_exception;
  logic            cp0_eret;
  logic [4:0]      cp0_cause;
  logic [31:0]     cp0_pc;
  logic            status_we;
  logic [31:0]     status_wdata;
  logic            stall;
  logic            pc_sel;
  logic [31:0]     pc_redirect;
  logic [NIRQ-1:0] irq_ack;
  logic            in_handler;

  modport master (
    output syscall_req, break_req, teq_req, eret_req, irq, pc, status, epc,
    input  cp0_exception, cp0_eret, cp0_cause, cp0_pc, status_we, status_wdata,
           stall, pc_sel, pc_redirect, irq_ack, in_handler
  );

  modport slave (
    input  syscall_req, break_req, teq_req, eret_req, irq, pc, status, epc,
    output cp0_exception, cp0_eret, cp0_cause, cp0_pc, status_we, status_wdata,
           stall, pc_sel, pc_redirect, irq_ack, in_handler
  );
endinterface

// File: rtl/exc_ctrl.sv
// Exception/interrupt sequencer for the single-cycle MIPS CPU.
// Takes one trap or IRQ at a time (no nesting), drives the CP0 entry/eret
// strobes with the Status push/pop, and redirects the PC to the handler and
// back to EPC.
//
// state   | meaning
// IDLE    | normal execution, requests accepted (except in the EPC redirect cycle)
// ENTER   | CP0 exception strobe + Status push, faulting instruction held
// VECTOR  | fetch redirected to EXC_VECTOR
// HANDLER | handler running, waiting for eret
// RETURN  | CP0 eret strobe + Status pop; next cycle redirects to EPC
module exc_ctrl #(
  parameter int          NIRQ       = 8,
  parameter logic [31:0] EXC_VECTOR = 32'h00400004,
  parameter logic [4:0]  CAUSE_INT  = 5'd0,
  parameter logic [4:0]  CAUSE_SYS  = 5'd8,
  parameter logic [4:0]  CAUSE_BRK  = 5'd9,
  parameter logic [4:0]  CAUSE_TEQ  = 5'd13
) (
  input logic       clk,
  input logic       rst,
  exc_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ENTER,
    S_VECTOR,
    S_HANDLER,
    S_RETURN
  } state_t;

  state_t          state_q, state_d;
  logic [NIRQ-1:0] pend_q, pend_d;
  logic [NIRQ-1:0] irq_prev_q;
  logic [4:0]      cause_q, cause_d;
  logic [31:0]     epc_pc_q, epc_pc_d;
  logic            exc_q, exc_d;
  logic            eret_q, eret_d;
  logic            swe_q, swe_d;
  logic [31:0]     swdata_q, swdata_d;
  logic            pc_sel_q, pc_sel_d;
  logic [31:0]     redir_q, redir_d;
  logic            in_hand_q, in_hand_d;

  logic            ie;
  logic            teq_hit, brk_hit, sys_hit, sync_hit, int_hit;
  logic [NIRQ-1:0] int_vec, ack_sel, irq_ack;
  logic            accept;
  logic [4:0]      cause_sel;

  // Masking and prioritisation of the candidate requests in this cycle.
  always_comb begin
    ie       = bus.status[0];
    teq_hit  = ie & bus.teq_req     & bus.status[3];
    brk_hit  = ie & bus.break_req   & bus.status[2];
    sys_hit  = ie & bus.syscall_req & bus.status[1];
    sync_hit = teq_hit | brk_hit | sys_hit;
    int_vec  = ie ? (pend_q & bus.status[8 +: NIRQ]) : '0;
    int_hit  = |int_vec;

    // Lowest index wins: the last match scanning downward is kept.
    ack_sel = '0;
    for (int i = NIRQ - 1; i >= 0; i--) begin
      if (int_vec[i]) begin
        ack_sel    = '0;
        ack_sel[i] = 1'b1;
      end
    end

    if (teq_hit)      cause_sel = CAUSE_TEQ;
    else if (brk_hit) cause_sel = CAUSE_BRK;
    else if (sys_hit) cause_sel = CAUSE_SYS;
    else              cause_sel = CAUSE_INT;

    // The EPC redirect cycle is not a real instruction, so nothing is taken
    // there; a pending IRQ waits one more cycle.
    accept  = ~rst & (state_q == S_IDLE) & ~pc_sel_q & (sync_hit | int_hit);
    irq_ack = (accept & ~sync_hit) ? ack_sel : '0;

    // Set wins over a same-cycle acknowledge.
    pend_d = (pend_q & ~irq_ack) | (bus.irq & ~irq_prev_q);
  end

  // Next-state and registered-output computation for the sequencer.
  always_comb begin
    state_d   = state_q;
    cause_d   = cause_q;
    epc_pc_d  = epc_pc_q;
    exc_d     = 1'b0;
    eret_d    = 1'b0;
    swe_d     = 1'b0;
    swdata_d  = swdata_q;
    pc_sel_d  = 1'b0;
    redir_d   = redir_q;
    in_hand_d = in_hand_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d  = S_ENTER;
          cause_d  = cause_sel;
          epc_pc_d = bus.pc;
          exc_d    = 1'b1;
          swe_d    = 1'b1;
          swdata_d = bus.status << 5;
        end
      end
      S_ENTER: begin
        state_d   = S_VECTOR;
        pc_sel_d  = 1'b1;
        redir_d   = EXC_VECTOR;
        in_hand_d = 1'b1;
      end
      S_VECTOR: begin
        state_d = S_HANDLER;
      end
      S_HANDLER: begin
        if (bus.eret_req) begin
          state_d  = S_RETURN;
          eret_d   = 1'b1;
          swe_d    = 1'b1;
          swdata_d = bus.status >> 5;
        end
      end
      S_RETURN: begin
        state_d   = S_IDLE;
        pc_sel_d  = 1'b1;
        redir_d   = bus.epc;
        in_hand_d = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and registered outputs; reset abandons any in-flight sequence.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      pend_q     <= '0;
      irq_prev_q <= '0;
      cause_q    <= '0;
      epc_pc_q   <= '0;
      exc_q      <= 1'b0;
      eret_q     <= 1'b0;
      swe_q      <= 1'b0;
      swdata_q   <= '0;
      pc_sel_q   <= 1'b0;
      redir_q    <= '0;
      in_hand_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      irq_prev_q <= bus.irq;
      cause_q    <= cause_d;
      epc_pc_q   <= epc_pc_d;
      exc_q      <= exc_d;
      eret_q     <= eret_d;
      swe_q      <= swe_d;
      swdata_q   <= swdata_d;
      pc_sel_q   <= pc_sel_d;
      redir_q    <= redir_d;
      in_hand_q  <= in_hand_d;
    end
  end

  // Hold the faulting instruction on acceptance, during entry, and on eret.
  always_comb begin
    bus.stall = accept | (state_q == S_ENTER) | ((state_q == S_HANDLER) & bus.eret_req);
  end

  assign bus.cp0_exception = exc_q;
  assign bus.cp0_eret      = eret_q;
  assign bus.cp0_cause     = cause_q;
  assign bus.cp0_pc        = epc_pc_q;
  assign bus.status_we     = swe_q;
  assign bus.status_wdata  = swdata_q;
  assign bus.pc_sel        = pc_sel_q;
  assign bus.pc_redirect   = redir_q;
  assign bus.irq_ack       = irq_ack;
  assign bus.in_handler    = in_hand_q;

endmodule

// File: tb/tb_exc_ctrl.sv
// Bench for exc_ctrl: directed scenarios with literal spot checks, plus a
// timeline model (scheduled cycle numbers for each strobe) compared on every
// falling edge.
module tb_exc_ctrl;
  localparam int NIRQ = 8;
  localparam logic [31:0] VEC = 32'h00400004;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  exc_ctrl_if #(.NIRQ(NIRQ)) bus ();
  exc_ctrl #(.NIRQ(NIRQ)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- timeline model ----------------
  int              cyc = 0;
  int              t_ent = -1, t_vec = -1, t_ret = -1, t_red = -1;
  bit              m_busy = 0, m_wait = 0, m_inh = 0;
  logic [NIRQ-1:0] m_pend = '0, m_prev = '0;
  logic [4:0]      m_cause = '0;
  logic [31:0]     m_pc = '0, m_wd = '0, m_red = '0;
  logic [31:0]     m_st_acc = '0, m_st_ret = '0, m_epc = '0;

  always @(negedge clk) begin : model
    logic            e_exc, e_eret, e_swe, e_stall, e_psel, e_inh, take, sync, ie;
    logic [NIRQ-1:0] e_ack, elig;
    logic [31:0]     e_wd, e_red;
    logic [4:0]      c;
    if (rst) begin
      t_ent = -1; t_vec = -1; t_ret = -1; t_red = -1;
      m_busy = 0; m_wait = 0; m_inh = 0;
      m_pend = '0; m_prev = '0; m_cause = '0; m_pc = '0; m_wd = '0; m_red = '0;
      check("rst_exc", bus.cp0_exception, 0);
      check("rst_eret", bus.cp0_eret, 0);
      check("rst_swe", bus.status_we, 0);
      check("rst_stall", bus.stall, 0);
      check("rst_pcsel", bus.pc_sel, 0);
      check("rst_ack", bus.irq_ack, 0);
      check("rst_inh", bus.in_handler, 0);
      check("rst_cause", bus.cp0_cause, 0);
      check("rst_cp0pc", bus.cp0_pc, 0);
      check("rst_wdata", bus.status_wdata, 0);
      check("rst_redir", bus.pc_redirect, 0);
    end else begin
      cyc++;
      e_exc = 0; e_eret = 0; e_swe = 0; e_stall = 0; e_psel = 0; e_ack = '0;
      e_wd = m_wd; e_red = m_red; e_inh = m_inh; c = 5'd0; take = 0;
      if (cyc == t_ent) begin e_exc = 1; e_stall = 1; e_swe = 1; e_wd = m_st_acc << 5; end
      if (cyc == t_vec) begin e_psel = 1; e_red = VEC; e_inh = 1; end
      if (cyc == t_ret) begin e_eret = 1; e_swe = 1; e_wd = m_st_ret >> 5; m_epc = bus.epc; end
      if (cyc == t_red) begin e_psel = 1; e_red = m_epc; e_inh = 0; end
      if (m_wait && bus.eret_req) e_stall = 1;
      ie   = bus.status[0];
      sync = ie && ((bus.teq_req && bus.status[3]) || (bus.break_req && bus.status[2]) ||
                    (bus.syscall_req && bus.status[1]));
      elig = ie ? (m_pend & bus.status[8 +: NIRQ]) : '0;
      if (!m_busy && cyc != t_red && (sync || elig != 0)) begin
        take = 1; e_stall = 1;
        if (bus.teq_req && bus.status[3]) c = 5'd13;
        else if (bus.break_req && bus.status[2]) c = 5'd9;
        else if (bus.syscall_req && bus.status[1]) c = 5'd8;
        else begin
          c = 5'd0;
          for (int i = 0; i < NIRQ; i++) if (elig[i] && e_ack == 0) e_ack[i] = 1'b1;
        end
      end
      check("exc", bus.cp0_exception, e_exc);
      check("eret", bus.cp0_eret, e_eret);
      check("swe", bus.status_we, e_swe);
      check("wdata", bus.status_wdata, e_wd);
      check("stall", bus.stall, e_stall);
      check("pcsel", bus.pc_sel, e_psel);
      check("redir", bus.pc_redirect, e_red);
      check("ack", bus.irq_ack, e_ack);
      check("inh", bus.in_handler, e_inh);
      check("cause", bus.cp0_cause, m_cause);
      check("cp0pc", bus.cp0_pc, m_pc);
      m_wd = e_wd; m_red = e_red; m_inh = e_inh;
      if (m_wait && bus.eret_req) begin
        t_ret = cyc + 1; t_red = cyc + 2; m_st_ret = bus.status; m_wait = 0;
      end
      if (cyc == t_vec) m_wait = 1;
      if (cyc == t_ret) m_busy = 0;
      if (take) begin
        m_busy = 1; t_ent = cyc + 1; t_vec = cyc + 2;
        m_cause = c; m_pc = bus.pc; m_st_acc = bus.status;
      end
      m_pend = (m_pend & ~e_ack) | (bus.irq & ~m_prev);
      m_prev = bus.irq;
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic look();
    @(negedge clk);
  endtask

  // From the ENTER cycle: VECTOR, HANDLER with eret, RETURN, redirect, IDLE.
  task automatic finish_handler();
    step();                 // VECTOR
    step();                 // HANDLER
    bus.eret_req = 1'b1;
    step();                 // RETURN
    bus.eret_req = 1'b0;
    step();                 // EPC redirect
    step();                 // IDLE
  endtask

  initial begin
    bus.syscall_req = 0; bus.break_req = 0; bus.teq_req = 0; bus.eret_req = 0;
    bus.irq = '0; bus.pc = 32'h00400000; bus.status = 32'h0; bus.epc = 32'h0;
    step(); step();
    rst = 1'b0;
    look();
    check("t0_stall", bus.stall, 0);

    // 1: syscall entry
    step();
    bus.status = 32'h0000000F; bus.pc = 32'h00400100; bus.syscall_req = 1;
    look(); check("t1_stall", bus.stall, 1);
    step(); bus.syscall_req = 0;
    look();
    check("t1_exc", bus.cp0_exception, 1);
    check("t1_cause", bus.cp0_cause, 8);
    check("t1_pc", bus.cp0_pc, 32'h00400100);
    check("t1_wdata", bus.status_wdata, 32'h1E0);
    step(); look();
    check("t1_pcsel", bus.pc_sel, 1);
    check("t1_redir", bus.pc_redirect, 32'h00400004);
    step(); step();
    // 2: eret
    bus.status = 32'h1E0; bus.epc = 32'h00400100; bus.eret_req = 1;
    look(); check("t2_stall", bus.stall, 1);
    step(); bus.eret_req = 0;
    look();
    check("t2_eret", bus.cp0_eret, 1);
    check("t2_wdata", bus.status_wdata, 32'h0F);
    step(); look();
    check("t2_pcsel", bus.pc_sel, 1);
    check("t2_redir", bus.pc_redirect, 32'h00400100);
    check("t2_inh", bus.in_handler, 0);

    // 3: two IRQ edges together, lowest first, second after return
    step();
    bus.status = 32'h305; bus.irq = 8'h03;
    step(); look();
    check("t3_ack0", bus.irq_ack, 8'h01);
    step(); bus.irq = 8'h00;
    look(); check("t3_cause", bus.cp0_cause, 0);
    step(); step();
    bus.status = 32'h60A0; bus.eret_req = 1;
    step(); bus.eret_req = 0;
    look(); check("t3_wdata", bus.status_wdata, 32'h305);
    step(); bus.status = 32'h305;
    step(); look();
    check("t3_ack1", bus.irq_ack, 8'h02);
    step(); finish_handler();

    // 4: teq beats syscall; masked teq and idle eret do nothing
    bus.status = 32'h0F; bus.teq_req = 1; bus.syscall_req = 1;
    look(); check("t4_stall", bus.stall, 1);
    step(); bus.teq_req = 0; bus.syscall_req = 0;
    look(); check("t4_cause", bus.cp0_cause, 13);
    finish_handler();
    bus.status = 32'h07; bus.teq_req = 1; bus.eret_req = 1;
    look(); check("t4_mstall", bus.stall, 0);
    step(); bus.teq_req = 0; bus.eret_req = 0;
    look(); check("t4_mexc", bus.cp0_exception, 0);

    // 5: global disable holds off everything; IRQ stays pending
    step();
    bus.status = 32'h10E; bus.syscall_req = 1; bus.irq = 8'h01;
    look(); check("t5_stall0", bus.stall, 0);
    step(); look(); check("t5_stall1", bus.stall, 0);
    step(); bus.syscall_req = 0;
    step(); bus.status = 32'h101;
    look(); check("t5_ack", bus.irq_ack, 8'h01);
    step(); bus.irq = 8'h00;
    finish_handler();

    // 7: break with simultaneous syscall and IRQ; IRQ taken after return
    bus.status = 32'h10F; bus.break_req = 1; bus.syscall_req = 1; bus.irq = 8'h01;
    look(); check("t7_ack0", bus.irq_ack, 0);
    step(); bus.break_req = 0; bus.syscall_req = 0;
    look(); check("t7_cause", bus.cp0_cause, 9);
    finish_handler();
    look(); check("t7_ack1", bus.irq_ack, 8'h01);
    step(); bus.irq = 8'h00;
    finish_handler();

    // 6: reset in ENTER, then a clean syscall
    bus.status = 32'h0F; bus.pc = 32'h00400200; bus.syscall_req = 1;
    step(); bus.syscall_req = 0;
    #2 rst = 1'b1;
    look();
    check("t6_exc", bus.cp0_exception, 0);
    check("t6_swe", bus.status_we, 0);
    check("t6_cause", bus.cp0_cause, 0);
    step(); rst = 1'b0;
    step();
    bus.pc = 32'h00400300; bus.syscall_req = 1;
    look(); check("t6_stall", bus.stall, 1);
    step(); bus.syscall_req = 0;
    look();
    check("t6_cause2", bus.cp0_cause, 8);
    check("t6_pc2", bus.cp0_pc, 32'h00400300);
    finish_handler();
    step(); step(); look();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
